cvxif_result_buf: RTL and testbench
===================================

CVXIF_RESULT_BUF -- requirements
Module: cvxif_result_buf

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of result entries; power of two, minimum 2.
REQ-002 SHALL have parameter ID_W, 4, width of the instruction id tag.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  discard all buffered results.
REQ-006 SHALL have port in_valid  in  1  coprocessor result valid.
REQ-007 SHALL have port in_ready  out  1  buffer can accept a result.
REQ-008 SHALL have port in_data  in  32  result value.
REQ-009 SHALL have port in_rd  in  5  destination register index.
REQ-010 SHALL have port in_id  in  ID_W  instruction id.
REQ-011 SHALL have port out_valid  out  1  result presented to the core.
REQ-012 SHALL have port out_ready  in  1  core accepts the result.
REQ-013 SHALL have ports out_data  out  32, out_rd  out  5, out_id  out  ID_W  head entry fields.
REQ-014 SHALL have port out_we  out  1  register write enable, 1 iff out_rd != 0.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-016 SHALL push an entry when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH) && !flush; in_ready SHALL NOT depend on out_ready.
REQ-018 SHALL deliver results in push order (FIFO), with no reordering by id.
REQ-019 SHALL, without bypass, assert out_valid exactly 1 cycle after the first push into an empty buffer.
REQ-020 SHALL allow a push and a pop in the same cycle when not full and not empty; count is then unchanged.
REQ-021 SHALL refuse a push when full, even if a pop occurs in the same cycle.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL hold out_data, out_rd, out_id and out_we stable while out_valid && !out_ready.
REQ-024 SHALL, on flush, set count to 0 and both pointers to 0 at the next edge, ignore any same-cycle push or pop, and drive out_valid = 0 during the flush cycle.

Reset
REQ-025 SHALL, while rst is high, clear the pointers and set count = 0; out_valid = 0, in_ready = 0.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst deasserts.
REQ-027 SHALL discard a handshake that coincides with rst; entry payload registers need no reset.
REQ-028 SHALL, when rst is asserted mid-operation, behave as a flush and take priority over flush.

Configuration
REQ-029 SHALL use macro CVXIF_RESULT_BYPASS_EN.
REQ-030 SHALL, when the macro is defined and count == 0, drive out_valid = in_valid and out_* = in_*, with in_ready unchanged.
REQ-031 SHALL, in that bypass case, not store the result when out_ready = 1, and store it normally when out_ready = 0.
REQ-032 SHALL, when the macro is undefined, have no combinational path from in_* to out_*.

Structure
REQ-033 SHALL take result_t {data[31:0], rd[4:0], id[ID_W-1:0]} and the XLEN constant (32) from the shared package cvxif_pkg.
REQ-034 SHALL implement storage as a flat result_t array with inline pointer and count logic; no sub-module.

Verification
REQ-035 SHALL cover: reset, then push {0x3F80_0000, rd=5, id=1} -> out_valid next cycle, out_data 0x3F80_0000, out_we 1; count 1 -> 0 after out_ready.
REQ-036 SHALL cover: DEPTH=4, out_ready=0, 5 pushes offered -> first 4 accepted, in_ready 0 on the 5th, count 4; drain returns ids 0,1,2,3 in order.
REQ-037 SHALL cover: count=2, simultaneous push and pop -> count stays 2; after 6 such cycles the pointers have wrapped and the data order is preserved.
REQ-038 SHALL cover: count=3, flush together with in_valid=1 -> count 0 next cycle, no entry stored, out_valid 0.
REQ-039 SHALL cover: push with in_rd=0 -> out_we 0 and the entry is still delivered and popped.
REQ-040 SHALL cover, with CVXIF_RESULT_BYPASS_EN: empty buffer, in_valid=1, out_ready=1 -> same-cycle out_valid and out_data = in_data, count stays 0.

Source files
------------

// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF result types used by the coprocessor result path.
package cvxif_pkg;

  localparam int unsigned XLEN = 32;

  // System-wide instruction id width; result buffer instances use the same ID_W.
  localparam int unsigned CVXIF_ID_W = 4;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [4:0]            rd;
    logic [CVXIF_ID_W-1:0] id;
  } result_t;

endpackage

// File: rtl/cvxif_result_buf.sv
// In-order FIFO holding coprocessor results until the core writes them back.
// Optional CVXIF_RESULT_BYPASS_EN: an empty buffer forwards in_* straight to out_*.
module cvxif_result_buf
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_data,
  input  logic [4:0]               in_rd,
  input  logic [ID_W-1:0]          in_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [4:0]               out_rd,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_we,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  result_t        mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  cnt;

  logic           running;
  logic           empty;
  logic           push;
  logic           store;
  logic           pop;
  result_t        wdata;
  result_t        head;

  assign running  = !rst && !flush;
  assign empty    = (cnt == '0);
  assign in_ready = running && (cnt != FULL);
  assign push     = in_valid && in_ready;

  always_comb begin
    wdata      = '0;
    wdata.data = in_data;
    wdata.rd   = in_rd;
    wdata.id   = CVXIF_ID_W'(in_id);
  end

  always_comb begin
    head      = mem[rd_ptr];
    out_valid = running && !empty;
    store     = push;
`ifdef CVXIF_RESULT_BYPASS_EN
    // Empty buffer: present the incoming result now; keep it only if the core stalls.
    if (empty) begin
      head      = wdata;
      out_valid = in_valid && running;
      store     = push && !out_ready;
    end
`endif
  end

  // Storage pops only when it actually held the presented entry.
  assign pop = out_valid && out_ready && !empty;

  assign out_data = head.data;
  assign out_rd   = head.rd;
  assign out_id   = ID_W'(head.id);
  assign out_we   = (head.rd != 5'd0);
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (!running) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_cvxif_result_buf.sv
// Randomized and directed checks of cvxif_result_buf against a queue model.
module tb_cvxif_result_buf;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_we;
  logic [31:0]     in_data, out_data;
  logic [4:0]      in_rd, out_rd;
  logic [ID_W-1:0] in_id, out_id;
  logic [2:0]      count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]     d;
    logic [4:0]      rd;
    logic [ID_W-1:0] id;
  } ent_t;

  ent_t q[$];

  cvxif_result_buf #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_id(out_id),
    .out_we(out_we), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] rd, input logic [ID_W-1:0] id);
    in_valid = 1'b1; in_data = d; in_rd = rd; in_id = id;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic step();
    logic exp_ready, exp_valid, push, pop;
    bit   byp;
    ent_t e;
    #1;
    byp       = 0;
    exp_ready = !rst && !flush && (q.size() != DEPTH);
    exp_valid = !rst && !flush && (q.size() != 0);
    if (q.size() != 0) e = q[0];
`ifdef CVXIF_RESULT_BYPASS_EN
    if (q.size() == 0) begin
      byp       = 1;
      exp_valid = in_valid && !rst && !flush;
      e         = '{in_data, in_rd, in_id};
    end
`endif
    chk_eq("in_ready", in_ready, exp_ready);
    chk_eq("out_valid", out_valid, exp_valid);
    chk_eq("count", count, q.size());
    if (exp_valid) begin
      chk_eq("out_data", out_data, e.d);
      chk_eq("out_rd", out_rd, e.rd);
      chk_eq("out_id", out_id, e.id);
      chk_eq("out_we", out_we, e.rd != 5'd0);
    end
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      push = in_valid && exp_ready;
      pop  = exp_valid && out_ready;
      if (byp) begin
        if (push && !out_ready) q.push_back(e);
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{in_data, in_rd, in_id});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    in_data = '0; in_rd = '0; in_id = '0;
    rst = 1'b1;
    @(negedge clk);
    step();
    step();

    rst = 1'b0;
    #1 chk_eq("ready_after_rst", in_ready, 1'b1);
    step();

    // Single result round trip
    offer(32'h3F80_0000, 5'd5, 4'd1);
    step();
    idle();
    #1;
    chk_eq("first_valid", out_valid, 1'b1);
    chk_eq("first_data", out_data, 32'h3F80_0000);
    chk_eq("first_we", out_we, 1'b1);
    chk_eq("first_count", count, 3'd1);
    out_ready = 1'b1;
    step();
    idle();
    #1 chk_eq("first_drained", count, 3'd0);
    step();

    // Fill to full with a fifth offer refused
    for (int i = 0; i < 5; i++) begin
      offer($urandom, 5'(i + 1), ID_W'(i));
      if (i == 4) begin
        #1;
        chk_eq("full_ready", in_ready, 1'b0);
        chk_eq("full_count", count, 3'd4);
      end
      step();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_eq("drain_id", out_id, ID_W'(i));
      step();
    end
    idle();
    step();

    // Simultaneous push/pop with pointer wrap
    for (int i = 0; i < 2; i++) begin
      offer($urandom, 5'd7, ID_W'(i));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      offer($urandom, 5'(i + 10), ID_W'(i + 2));
      out_ready = 1'b1;
      step();
    end
    idle();
    #1 chk_eq("pushpop_count", count, 3'd2);
    out_ready = 1'b1;
    step();
    step();
    idle();
    step();

    // Flush with a concurrent offer
    for (int i = 0; i < 3; i++) begin
      offer($urandom, 5'd3, ID_W'(i));
      step();
    end
    flush = 1'b1;
    offer(32'hDEAD_BEEF, 5'd9, 4'd9);
    #1 chk_eq("flush_valid", out_valid, 1'b0);
    step();
    idle();
    #1;
    chk_eq("flush_count", count, 3'd0);
    chk_eq("flush_empty", out_valid, 1'b0);
    step();

    // rd = 0 is delivered without a register write
    offer(32'h1234_5678, 5'd0, 4'd6);
    step();
    idle();
    #1;
    chk_eq("rd0_valid", out_valid, 1'b1);
    chk_eq("rd0_we", out_we, 1'b0);
    out_ready = 1'b1;
    step();
    idle();
    step();

`ifdef CVXIF_RESULT_BYPASS_EN
    offer(32'hA5A5_5A5A, 5'd4, 4'd3);
    out_ready = 1'b1;
    #1;
    chk_eq("byp_valid", out_valid, 1'b1);
    chk_eq("byp_data", out_data, 32'hA5A5_5A5A);
    step();
    idle();
    #1 chk_eq("byp_count", count, 3'd0);
    step();
`endif

    // Randomized traffic with varying producer/consumer bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias      = (i / 250) % 3;
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = (bias == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      out_ready = (bias == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      in_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_id     = ID_W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
